// File: rtl/data_mem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   mem_in_s    : request/handshake bundle driven toward data_mem
//   mem_out_s   : handshake/read-data bundle returned by data_mem
//   lsu_state_e : LSU sequencing states
//   load_extend : shapes raw read data into the 32-bit load result
package data_mem_lsu_pkg;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] write_data;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic        valid;
    logic        yumi;
    logic [31:0] read_data;
  } mem_out_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  function automatic logic [31:0] load_extend(input logic [31:0] data,
                                              input logic        is_byte,
                                              input logic        sign_ext);
    logic [31:0] res;
    if (!is_byte)
      res = data;
    else if (sign_ext)
      res = {{24{data[7]}}, data[7:0]};
    else
      res = {24'b0, data[7:0]};
    return res;
  endfunction

endpackage

// File: rtl/data_mem_lsu.sv
// Load/store unit between the core execute stage and the data_mem port.
// Latches a one-cycle core request, runs the valid/yumi handshake with
// data_mem, and returns a one-cycle response (with byte sign-extension on
// loads). Misaligned word accesses are answered with an error response
// without touching memory.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   req_valid_i           core request strobe (sampled only in IDLE)
//   req_wen_i             1 = store, 0 = load
//   req_byte_i            1 = byte access, 0 = word access
//   req_signed_i          sign-extend byte loads
//   req_addr_i            byte address
//   req_wdata_i           store data (byte stores use [7:0])
//   stall_o               request in flight
//   resp_valid_o          one-cycle completion pulse
//   resp_data_o           load result, 0 for stores and errors
//   resp_err_o            misaligned word access
//   mem_port_flat_o       mem_in_s toward data_mem
//   mem_addr_o            address toward data_mem
//   mem_port_flat_i       mem_out_s from data_mem
//
// state | meaning
// IDLE  | no transaction; accepts core requests
// REQ   | mem_in.valid high, waiting for data_mem yumi
// WAIT  | request accepted, waiting for data_mem valid
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int addr_width_p = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid_i,
  input  logic                          req_wen_i,
  input  logic                          req_byte_i,
  input  logic                          req_signed_i,
  input  logic [addr_width_p-1:0]       req_addr_i,
  input  logic [31:0]                   req_wdata_i,
  output logic                          stall_o,
  output logic                          resp_valid_o,
  output logic [31:0]                   resp_data_o,
  output logic                          resp_err_o,
  output logic [$bits(mem_in_s)-1:0]    mem_port_flat_o,
  output logic [addr_width_p-1:0]       mem_addr_o,
  input  logic [$bits(mem_out_s)-1:0]   mem_port_flat_i
);

  lsu_state_e state_r, state_n;

  logic                    wen_r;
  logic                    byte_r;
  logic                    signed_r;
  logic [addr_width_p-1:0] addr_r;
  logic [31:0]             wdata_r;

  logic                    resp_valid_r;
  logic                    resp_err_r;
  logic [31:0]             resp_data_r;

  mem_in_s  mem_in;
  mem_out_s mem_out;
  logic     misaligned;

  assign mem_out    = mem_port_flat_i;
  assign misaligned = ~req_byte_i & (req_addr_i[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!reset)
      state_r <= IDLE;
    else
      state_r <= state_n;
  end

  always_comb begin
    state_n              = state_r;
    mem_in               = '0;
    mem_in.wen           = wen_r;
    mem_in.byte_not_word = byte_r;
    mem_in.write_data    = wdata_r;
    case (state_r)
      IDLE: begin
        if (req_valid_i && !misaligned)
          state_n = REQ;
      end
      REQ: begin
        mem_in.valid = 1'b1;
        if (mem_out.yumi)
          state_n = WAIT;
      end
      WAIT: begin
        // valid stays low here so data_mem cannot re-accept the request
        // when it returns to its own idle state.
        if (mem_out.valid) begin
          mem_in.yumi = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Request latch and response registers. The response is a single-cycle
  // pulse; data and error are cleared whenever no response is presented.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wen_r        <= 1'b0;
      byte_r       <= 1'b0;
      signed_r     <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_data_r  <= '0;
    end else begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_data_r  <= '0;
      case (state_r)
        IDLE: begin
          if (req_valid_i) begin
            if (misaligned) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else begin
              wen_r    <= req_wen_i;
              byte_r   <= req_byte_i;
              signed_r <= req_signed_i;
              addr_r   <= req_addr_i;
              wdata_r  <= req_wdata_i;
            end
          end
        end
        WAIT: begin
          if (mem_out.valid) begin
            resp_valid_r <= 1'b1;
            resp_data_r  <= wen_r ? 32'h0
                                  : load_extend(mem_out.read_data, byte_r, signed_r);
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o         = (state_r != IDLE);
  assign resp_valid_o    = resp_valid_r;
  assign resp_err_o      = resp_err_r;
  assign resp_data_o     = resp_data_r;
  assign mem_addr_o      = addr_r;
  assign mem_port_flat_o = mem_in;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: a behavioural data_mem responder
// with programmable yumi delay, and a byte-array reference model that
// predicts every response from the load/store rules.
module tb_data_mem_lsu;
  import data_mem_lsu_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_wen = 1'b0;
  logic          req_byte = 1'b0;
  logic          req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          stall;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic [$bits(mem_in_s)-1:0]  mem_port_flat_o;
  logic [AW-1:0]               mem_addr;
  logic [$bits(mem_out_s)-1:0] mem_port_flat_i;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_lsu #(.addr_width_p(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid_i     (req_valid),
    .req_wen_i       (req_wen),
    .req_byte_i      (req_byte),
    .req_signed_i    (req_signed),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .stall_o         (stall),
    .resp_valid_o    (resp_valid),
    .resp_data_o     (resp_data),
    .resp_err_o      (resp_err),
    .mem_port_flat_o (mem_port_flat_o),
    .mem_addr_o      (mem_addr),
    .mem_port_flat_i (mem_port_flat_i)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural data_mem responder ----------------
  mem_in_s  mi;
  mem_out_s mo;
  logic [7:0]  mem [0:(1<<AW)-1];
  bit          mem_inited = 1'b0;
  logic        r_valid = 1'b0;
  logic [31:0] r_data = '0;
  int          r_cnt = 0;
  int          yumi_extra = 0;
  int          n_accept = 0;
  int          n_valid_cyc = 0;
  logic        m_yumi;

  assign mi     = mem_in_s'(mem_port_flat_o);
  assign m_yumi = mi.valid && !r_valid && (r_cnt >= yumi_extra);

  always_comb begin
    mo           = '0;
    mo.valid     = r_valid;
    mo.yumi      = m_yumi;
    mo.read_data = r_data;
  end
  assign mem_port_flat_i = mo;

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
      mem_inited <= 1'b1;
    end
    if (mi.valid) n_valid_cyc <= n_valid_cyc + 1;
    if (!reset) begin
      r_valid <= 1'b0;
      r_cnt   <= 0;
    end else begin
      if (r_valid && mi.yumi) r_valid <= 1'b0;
      if (m_yumi) begin
        r_cnt    <= 0;
        r_valid  <= 1'b1;
        n_accept <= n_accept + 1;
        if (mi.wen) begin
          mem[mem_addr] <= mi.write_data[7:0];
          if (!mi.byte_not_word) begin
            mem[AW'(mem_addr + 1)] <= mi.write_data[15:8];
            mem[AW'(mem_addr + 2)] <= mi.write_data[23:16];
            mem[AW'(mem_addr + 3)] <= mi.write_data[31:24];
          end
          r_data <= $urandom;
        end else if (mi.byte_not_word) begin
          // upper bits are junk: the LSU must discard them
          r_data <= {$urandom_range(0, 32'hFFFFFF) , mem[mem_addr]} ;
        end else begin
          r_data <= {mem[AW'(mem_addr + 3)], mem[AW'(mem_addr + 2)],
                     mem[AW'(mem_addr + 1)], mem[mem_addr]};
        end
      end else if (mi.valid && !r_valid) begin
        r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  int unsigned ref_mem [0:(1<<AW)-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue a request in the current cycle (caller is at a negedge) and follow
  // it to its response. Returns at the negedge where resp_valid is seen.
  task automatic txn(input logic wen, input logic byt, input logic sgn,
                     input logic [AW-1:0] addr, input logic [31:0] wd,
                     input int extra, input logic spurious);
    logic        exp_err;
    logic [31:0] exp_data;
    int unsigned v;
    int          exp_lat, n, stalls, acc0, vc0;
    logic        got;
    logic [31:0] rdata;
    logic        rerr;
    logic [AW-1:0] a;

    exp_err  = !byt && (addr[1:0] != 2'b00);
    exp_data = 32'h0;
    if (!exp_err && !wen) begin
      if (byt) begin
        v = ref_mem[addr];
        exp_data = (sgn && v >= 128) ? 32'hFFFFFF00 + v : v;
      end else begin
        exp_data = 0;
        for (int k = 3; k >= 0; k--) begin
          a = AW'(addr + k);
          exp_data = exp_data * 256 + ref_mem[a];
        end
      end
    end
    if (!exp_err && wen) begin
      ref_mem[addr] = wd % 256;
      if (!byt)
        for (int k = 1; k < 4; k++) begin
          a = AW'(addr + k);
          ref_mem[a] = (wd >> (8 * k)) % 256;
        end
    end
    exp_lat = exp_err ? 1 : 3 + extra;

    yumi_extra = extra;
    acc0       = n_accept;
    vc0        = n_valid_cyc;
    req_valid  = 1'b1;
    req_wen    = wen;
    req_byte   = byt;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;

    n = 0; stalls = 0; got = 1'b0; rdata = '0; rerr = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      req_valid = 1'b0;
      if (spurious && !exp_err && n <= 2) begin
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 12'h200;
        req_wdata = $urandom;
      end
      if (stall) stalls++;
      if (!exp_err && n <= 1 + extra) begin
        check("req_valid_held", {31'b0, mi.valid}, 32'h1);
        check("req_addr_held", {20'b0, mem_addr}, {20'b0, addr});
      end
      if (!exp_err && n == 2 + extra)
        check("wait_valid_low", {31'b0, mi.valid}, 32'h0);
      if (resp_valid) begin
        got   = 1'b1;
        rdata = resp_data;
        rerr  = resp_err;
      end
    end
    req_valid = 1'b0;
    check("latency", n, exp_lat);
    check("stall_cycles", stalls, exp_err ? 0 : 2 + extra);
    check("resp_data", rdata, exp_data);
    check("resp_err", {31'b0, rerr}, {31'b0, exp_err});
    check("mem_accepts", n_accept - acc0, exp_err ? 0 : 1);
    if (exp_err) check("no_mem_valid", n_valid_cyc - vc0, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 0;
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          w, b, s;
    logic [AW-1:0] a;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", {31'b0, resp_err}, 0);
    check("rst_mem_valid", {31'b0, mi.valid}, 0);
    check("rst_mem_yumi", {31'b0, mi.yumi}, 0);
    check("rst_mem_addr", {20'b0, mem_addr}, 0);
    reset = 1'b1;
    @(negedge clk);

    txn(1'b1, 1'b0, 1'b0, 12'h010, 32'hDEADBEEF, 0, 1'b0);
    @(negedge clk);
    txn(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 0, 1'b0);
    check("word_load_dir", resp_data, 32'hDEADBEEF);

    @(negedge clk);
    txn(1'b1, 1'b1, 1'b0, 12'h021, 32'hABCDEF80, 0, 1'b0);
    @(negedge clk);
    txn(1'b0, 1'b1, 1'b0, 12'h021, 32'h0, 0, 1'b0);
    check("byte_unsigned_dir", resp_data, 32'h00000080);
    @(negedge clk);
    txn(1'b0, 1'b1, 1'b1, 12'h021, 32'h0, 0, 1'b0);
    check("byte_signed_dir", resp_data, 32'hFFFFFF80);

    @(negedge clk);
    txn(1'b0, 1'b0, 1'b0, 12'h013, 32'h0, 0, 1'b0);

    // back-to-back, with requests attempted while stalled
    @(negedge clk);
    txn(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 0, 1'b1);
    txn(1'b0, 1'b1, 1'b1, 12'h021, 32'h0, 0, 1'b0);
    txn(1'b0, 1'b0, 1'b0, 12'h200, 32'h0, 0, 1'b0);

    // reset while in WAIT
    @(negedge clk);
    yumi_extra = 0;
    req_valid = 1'b1; req_wen = 1'b0; req_byte = 1'b0; req_addr = 12'h010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("wait_stall", {31'b0, stall}, 1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_stall", {31'b0, stall}, 0);
    check("abort_resp_valid", {31'b0, resp_valid}, 0);
    check("abort_resp_data", resp_data, 0);
    check("abort_mem_valid", {31'b0, mi.valid}, 0);
    check("abort_mem_yumi", {31'b0, mi.yumi}, 0);
    check("abort_mem_addr", {20'b0, mem_addr}, 0);
    reset = 1'b1;
    @(negedge clk);
    txn(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 0, 1'b0);
    check("post_abort_load", resp_data, 32'hDEADBEEF);

    // delayed yumi
    @(negedge clk);
    txn(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 2, 1'b0);

    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = AW'(12'h100 + $urandom_range(0, 63));
      if (!b && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      txn(w, b, s, a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store unit sitting directly upstream of `data_mem`, between the core's execute stage and the data memory port.
- Accepts one-cycle load/store requests from the core and latches them.
- Runs the full valid/yumi handshake with `data_mem`, then returns load data with optional byte sign-extension.
- Holds the core stalled while a transaction is outstanding.
- Rejects misaligned word accesses without touching memory.

## Interface
- `addr_width_p`, 12, byte-address width; must equal the connected `data_mem` `addr_width_p`.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  1  core request strobe; sampled only in IDLE.
- `req_wen_i`  in  1  1 = store, 0 = load.
- `req_byte_i`  in  1  1 = byte access, 0 = word access.
- `req_signed_i`  in  1  byte load sign-extends when 1; ignored otherwise.
- `req_addr_i`  in  `addr_width_p`  byte address.
- `req_wdata_i`  in  32  store data; byte store uses [7:0].
- `stall_o`  out  1  request in flight; the core must hold off.
- `resp_valid_o`  out  1  one-cycle completion pulse.
- `resp_data_o`  out  32  load result; 0 for stores and errors.
- `resp_err_o`  out  1  misaligned word access; qualified by `resp_valid_o`.
- `mem_port_flat_o`  out  `$bits(mem_in_s)`  to `data_mem` `port_flat_i`.
- `mem_addr_o`  out  `addr_width_p`  to `data_mem` `addr`.
- `mem_port_flat_i`  in  `$bits(mem_out_s)`  from `data_mem` `port_flat_o`.

## Operation
- States: IDLE, REQ, WAIT.
- **IDLE**
  - On `req_valid_i=1` with word access and `req_addr_i[1:0]!=0`:
    - next cycle `resp_valid_o=1`, `resp_err_o=1`, `resp_data_o=0`;
    - stay in IDLE; no memory access.
  - On any other `req_valid_i=1`: latch wen, byte, signed, addr and wdata; go to REQ.
- **REQ**
  - Drive `mem_in.valid=1`, with `wen`, `byte_not_word`, `write_data` and `mem_addr_o` taken from the latched registers.
  - Go to WAIT when `mem_out.yumi=1`; otherwise hold REQ with all outputs stable.
- **WAIT**
  - `mem_in.valid=0`.
  - When `mem_out.valid=1`:
    - drive `mem_in.yumi=1` combinationally in the same cycle;
    - capture the load result;
    - next cycle `resp_valid_o=1` and `resp_data_o` valid;
    - go to IDLE.
  - Otherwise hold WAIT.
- `mem_in.yumi` is asserted only in WAIT with `mem_out.valid=1`. A `mem_out.valid` seen in IDLE or REQ is ignored.
- Load result:
  - word load: `read_data` as is;
  - byte load, signed: `{{24{read_data[7]}}, read_data[7:0]}`;
  - byte load, unsigned: `{24'b0, read_data[7:0]}`.
- Stores complete with `resp_data_o=0` and `resp_err_o=0`.
- `stall_o = (state != IDLE)`, combinational.
- `req_valid_i` is ignored outside IDLE; such a request is dropped, not queued.
- `mem_addr_o` holds its last latched value outside REQ.
- A request is accepted in IDLE in the same cycle `resp_valid_o` is high (back-to-back).

## Timing
- Reset (`reset==0` at a clock edge), from the next cycle:
  - state IDLE;
  - `resp_valid_o=0`, `resp_data_o=0`, `resp_err_o=0`;
  - `mem_in.valid=0`, `mem_in.yumi=0`, `mem_addr_o=0`;
  - `stall_o=0`.
- Reset mid-transaction aborts it with no response; `data_mem` shares the reset and also returns to IDLE.
- Load or store, `data_mem` yumi immediate:
  - request at cycle 0 (IDLE);
  - REQ at cycle 1;
  - WAIT at cycle 2 (mem valid high, yumi sent);
  - `resp_valid_o` at cycle 3.
  - Latency 3; `stall_o` high in cycles 1–2.
- Misaligned word: `resp_valid_o` at cycle 1; `stall_o` never asserts.
- Back-to-back throughput: one transaction per 3 cycles.
- `mem_in.valid` is never high in WAIT. This guarantees `data_mem` does not re-accept a request on its return to IDLE.

## Structure
- `mem_in_s` / `mem_out_s` come from the shared definitions package.
- Add to the same package:
  - a `lsu_state_e` enum (IDLE/REQ/WAIT);
  - a `load_extend` function (data, byte, signed → 32-bit).
- Single module; no sub-module. The integration top instantiates `data_mem_lsu` beside `data_mem`.

## Test plan
- Store word 0xDEADBEEF to 0x010, then load word from 0x010 → `resp_data_o=0xDEADBEEF` at cycle 3 after the load request; `stall_o` high exactly 2 cycles.
- Store byte 0x80 to 0x021; byte load unsigned from 0x021 → 0x00000080; byte load signed from 0x021 → 0xFFFFFF80.
- Word load from 0x013 → `resp_valid_o` and `resp_err_o` next cycle, `resp_data_o=0`; no `mem_in.valid` pulse observed.
- Two loads back-to-back, second request issued in the cycle the first `resp_valid_o` is high → second response exactly 3 cycles later; `req_valid_i` asserted while `stall_o=1` produces no transaction.
- Reset asserted in WAIT → next cycle all outputs 0 and state IDLE; a following load from 0x010 completes normally.
- Memory model withholding yumi in REQ for 2 extra cycles → FSM holds REQ with stable valid/addr; response arrives 2 cycles later.
